// File: rtl/up_wishbone_classic_master.sv
// Purpose: bridges the up_* register request bus onto a Wishbone Classic master (single, non-burst cycles).
// Latency: request pulse to up_*ack is 2 cycles with a zero-wait slave; each transfer is followed by BUS idle + IDLE.
// Backpressure: none toward the requester; one pending request per direction, cycles abort after TIMEOUT stb cycles.
//
// Ports:
//   clk, rstn                      - clock, asynchronous active-low reset
//   up_rreq/up_raddr               - read request pulse and word address
//   up_rack/up_rdata/up_rerr       - read done pulse, data and error (valid with up_rack)
//   up_wreq/up_waddr/up_wdata      - write request pulse, word address and data
//   up_wack/up_werr                - write done pulse and error (valid with up_wack)
//   m_wb_*                         - Wishbone Classic master port (cti/bte tied to classic, sel all ones)
module up_wishbone_classic_master #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          up_rreq,
  input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0]    up_raddr,
  output logic                                          up_rack,
  output logic [BUS_WIDTH*8-1:0]                        up_rdata,
  output logic                                          up_rerr,
  input  logic                                          up_wreq,
  input  logic [ADDRESS_WIDTH-$clog2(BUS_WIDTH)-1:0]    up_waddr,
  input  logic [BUS_WIDTH*8-1:0]                        up_wdata,
  output logic                                          up_wack,
  output logic                                          up_werr,
  output logic                                          m_wb_cyc,
  output logic                                          m_wb_stb,
  output logic                                          m_wb_we,
  output logic [ADDRESS_WIDTH-1:0]                      m_wb_addr,
  output logic [BUS_WIDTH*8-1:0]                        m_wb_data_o,
  output logic [BUS_WIDTH-1:0]                          m_wb_sel,
  output logic [2:0]                                    m_wb_cti,
  output logic [1:0]                                    m_wb_bte,
  input  logic                                          m_wb_ack,
  input  logic [BUS_WIDTH*8-1:0]                        m_wb_data_i,
  input  logic                                          m_wb_err
);

  localparam int LSB = $clog2(BUS_WIDTH);
  localparam int WAW = ADDRESS_WIDTH - LSB;
  localparam int DW  = BUS_WIDTH * 8;
  localparam int CW  = $clog2(TIMEOUT + 1);
  // Counter value seen at the edge that closes the TIMEOUT-th stb cycle.
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic            wr_pend;
  logic [WAW-1:0]  wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rd_pend;
  logic [WAW-1:0]  rd_addr;
  logic [CW-1:0]   tmo_cnt;

  logic            bus_term;
  logic            bus_err;

  // A cycle ends on ack, err or timeout. Anything other than a clean ack
  // (err present, or neither ack nor err, i.e. timeout) reports an error.
  assign bus_term = m_wb_ack | m_wb_err | (tmo_cnt == TO_LAST);
  assign bus_err  = m_wb_err | ~m_wb_ack;

  assign m_wb_cti = 3'b000;
  assign m_wb_bte = 2'b00;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      wr_pend     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      rd_pend     <= 1'b0;
      rd_addr     <= '0;
      tmo_cnt     <= '0;
      up_rack     <= 1'b0;
      up_rerr     <= 1'b0;
      up_rdata    <= '0;
      up_wack     <= 1'b0;
      up_werr     <= 1'b0;
      m_wb_cyc    <= 1'b0;
      m_wb_stb    <= 1'b0;
      m_wb_we     <= 1'b0;
      m_wb_addr   <= '0;
      m_wb_data_o <= '0;
      m_wb_sel    <= '0;
    end else begin
      // Done/error strobes are single-cycle pulses.
      up_rack <= 1'b0;
      up_rerr <= 1'b0;
      up_wack <= 1'b0;
      up_werr <= 1'b0;

      case (state)
        IDLE: begin
          // Write has priority; a read pending alongside it waits its turn.
          if (wr_pend) begin
            state       <= BUS;
            wr_pend     <= 1'b0;
            tmo_cnt     <= '0;
            m_wb_cyc    <= 1'b1;
            m_wb_stb    <= 1'b1;
            m_wb_we     <= 1'b1;
            m_wb_addr   <= ADDRESS_WIDTH'(wr_addr) << LSB;
            m_wb_data_o <= wr_data;
            m_wb_sel    <= '1;
          end else if (rd_pend) begin
            state       <= BUS;
            rd_pend     <= 1'b0;
            tmo_cnt     <= '0;
            m_wb_cyc    <= 1'b1;
            m_wb_stb    <= 1'b1;
            m_wb_we     <= 1'b0;
            m_wb_addr   <= ADDRESS_WIDTH'(rd_addr) << LSB;
            m_wb_sel    <= '1;
          end
        end

        BUS: begin
          if (bus_term) begin
            state    <= DONE;
            m_wb_cyc <= 1'b0;
            m_wb_stb <= 1'b0;
            m_wb_we  <= 1'b0;
            m_wb_sel <= '0;
            if (m_wb_we) begin
              up_wack <= 1'b1;
              up_werr <= bus_err;
            end else begin
              up_rack  <= 1'b1;
              up_rerr  <= bus_err;
              up_rdata <= bus_err ? '0 : m_wb_data_i;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        // One mandatory cycle with cyc low between transfers.
        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase

      // Request capture comes last so a pulse is never lost to a same-edge
      // clear of its latch.
      if (up_wreq) begin
        wr_pend <= 1'b1;
        wr_addr <= up_waddr;
        wr_data <= up_wdata;
      end
      if (up_rreq) begin
        rd_pend <= 1'b1;
        rd_addr <= up_raddr;
      end
    end
  end

endmodule

// File: tb/tb_up_wishbone_classic_master.sv
// Bench for up_wishbone_classic_master: table of directed transactions, random
// transactions against a transaction-level model, and hand sequences for
// simultaneous requests, spurious slave responses and asynchronous reset.
module tb_up_wishbone_classic_master;

  localparam int AW  = 16;
  localparam int BW  = 4;
  localparam int TO  = 8;
  localparam int WAW = 14;
  localparam int DW  = 32;

  logic            tb_data_clk = 1'b0;
  logic            rstn;
  logic            up_rreq;
  logic [WAW-1:0]  up_raddr;
  logic            up_rack;
  logic [DW-1:0]   up_rdata;
  logic            up_rerr;
  logic            up_wreq;
  logic [WAW-1:0]  up_waddr;
  logic [DW-1:0]   up_wdata;
  logic            up_wack;
  logic            up_werr;
  logic            m_wb_cyc;
  logic            m_wb_stb;
  logic            m_wb_we;
  logic [AW-1:0]   m_wb_addr;
  logic [DW-1:0]   m_wb_data_o;
  logic [BW-1:0]   m_wb_sel;
  logic [2:0]      m_wb_cti;
  logic [1:0]      m_wb_bte;
  logic            m_wb_ack = 1'b0;
  logic            m_wb_err = 1'b0;
  logic [DW-1:0]   sl_data  = '0;

  always #5 tb_data_clk = ~tb_data_clk;

  up_wishbone_classic_master #(
    .ADDRESS_WIDTH(AW),
    .BUS_WIDTH(BW),
    .TIMEOUT(TO)
  ) dut (
    .clk(tb_data_clk),
    .rstn(rstn),
    .up_rreq(up_rreq),
    .up_raddr(up_raddr),
    .up_rack(up_rack),
    .up_rdata(up_rdata),
    .up_rerr(up_rerr),
    .up_wreq(up_wreq),
    .up_waddr(up_waddr),
    .up_wdata(up_wdata),
    .up_wack(up_wack),
    .up_werr(up_werr),
    .m_wb_cyc(m_wb_cyc),
    .m_wb_stb(m_wb_stb),
    .m_wb_we(m_wb_we),
    .m_wb_addr(m_wb_addr),
    .m_wb_data_o(m_wb_data_o),
    .m_wb_sel(m_wb_sel),
    .m_wb_cti(m_wb_cti),
    .m_wb_bte(m_wb_bte),
    .m_wb_ack(m_wb_ack),
    .m_wb_data_i(sl_data),
    .m_wb_err(m_wb_err)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- slave model ----------------
  // resp: 0 ack, 1 err, 2 ack+err, 3 never respond
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    logic [BW-1:0] sel;
  } mon_t;

  int       sl_wait = 0;
  int       sl_resp = 0;
  int       sl_cnt  = 0;
  int       stb_cycles = 0;
  bit       stable = 1'b1;
  bit       spur = 1'b0;
  mon_t     mon_q[$];
  mon_t     cur;

  always @(negedge tb_data_clk) begin
    if (m_wb_cyc && m_wb_stb) begin
      if (sl_cnt == 0) begin
        cur.addr = m_wb_addr;
        cur.we   = m_wb_we;
        cur.data = m_wb_data_o;
        cur.sel  = m_wb_sel;
        mon_q.push_back(cur);
      end else if (cur.addr !== m_wb_addr || cur.we !== m_wb_we ||
                   cur.data !== m_wb_data_o || cur.sel !== m_wb_sel) begin
        stable = 1'b0;
      end
      stb_cycles++;
      m_wb_ack = (sl_cnt == sl_wait) && (sl_resp == 0 || sl_resp == 2);
      m_wb_err = (sl_cnt == sl_wait) && (sl_resp == 1 || sl_resp == 2);
      sl_cnt++;
    end else begin
      m_wb_ack = spur;
      m_wb_err = spur;
      sl_cnt   = 0;
    end
  end

  // ---------------- transaction vectors ----------------
  typedef struct {
    bit            wr;
    logic [WAW-1:0] addr;
    logic [DW-1:0] wdata;
    int            wait_c;
    int            resp;
    logic [DW-1:0] sdata;
    int            exp_lat;
    bit            exp_err;
    logic [DW-1:0] exp_rdata;   // for writes: the read data expected to be held
  } vec_t;

  vec_t tbl[10];
  logic [DW-1:0] model_rdata;

  // Transaction-level reference: a slave answering after w wait states
  // completes at w+2; no answer within TIMEOUT stb cycles completes at
  // TIMEOUT+1 as an error. Read data is zero on any error.
  task automatic model(inout vec_t v);
    if (v.resp == 3 || v.wait_c >= TO) begin
      v.exp_lat = TO + 1;
      v.exp_err = 1'b1;
    end else begin
      v.exp_lat = v.wait_c + 2;
      v.exp_err = (v.resp != 0);
    end
    if (v.wr) v.exp_rdata = model_rdata;
    else begin
      v.exp_rdata = v.exp_err ? '0 : v.sdata;
      model_rdata = v.exp_rdata;
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int lat;
    bit other;
    logic err_seen;
    logic [DW-1:0] rd_seen;
    lat = 0; other = 1'b0; err_seen = 1'b0; rd_seen = '0;
    sl_wait = v.wait_c; sl_resp = v.resp; sl_data = v.sdata;
    stb_cycles = 0; stable = 1'b1; mon_q.delete();
    @(negedge tb_data_clk);
    if (v.wr) begin up_wreq = 1'b1; up_waddr = v.addr; up_wdata = v.wdata; end
    else begin up_rreq = 1'b1; up_raddr = v.addr; end
    @(negedge tb_data_clk);
    up_wreq = 1'b0; up_rreq = 1'b0;
    up_waddr = WAW'($urandom); up_wdata = $urandom; up_raddr = WAW'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge tb_data_clk);
      if (v.wr ? up_rack : up_wack) other = 1'b1;
      if (v.wr ? up_wack : up_rack) begin
        lat = k;
        err_seen = v.wr ? up_werr : up_rerr;
        rd_seen = up_rdata;
        break;
      end
    end
    chk($sformatf("%s done_seen", tag), lat != 0, 1);
    if (lat != 0) begin
      chk($sformatf("%s latency", tag), lat, v.exp_lat);
      chk($sformatf("%s err", tag), err_seen, v.exp_err);
      chk($sformatf("%s rdata", tag), rd_seen, v.exp_rdata);
      chk($sformatf("%s stb_cycles", tag), stb_cycles, v.exp_lat - 1);
      chk($sformatf("%s held_stable", tag), stable, 1);
      chk($sformatf("%s n_wb_cycles", tag), mon_q.size(), 1);
      if (mon_q.size() == 1) begin
        chk($sformatf("%s wb_addr", tag), mon_q[0].addr, {v.addr, 2'b00});
        chk($sformatf("%s wb_we", tag), mon_q[0].we, v.wr);
        chk($sformatf("%s wb_sel", tag), mon_q[0].sel, 4'hF);
        if (v.wr) chk($sformatf("%s wb_data", tag), mon_q[0].data, v.wdata);
      end
      @(negedge tb_data_clk);
      chk($sformatf("%s ack_one_cycle", tag), {up_wack, up_rack, up_werr, up_rerr}, 4'b0000);
      chk($sformatf("%s cyc_gap", tag), m_wb_cyc, 1'b0);
    end
    chk($sformatf("%s no_other_ack", tag), other, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int wk, rk;
    logic wk_err, rk_err;
    logic [DW-1:0] rk_data;
    logic cyc_at[32];
    bit bad;

    rstn = 1'b0;
    up_rreq = 1'b0; up_wreq = 1'b0;
    up_raddr = '0; up_waddr = '0; up_wdata = '0;

    //           wr    addr      wdata         wait resp sdata         lat err rdata
    tbl[0] = '{1'b1, 14'h0001, 32'hAAAA0000, 2, 0, 32'h00000000, 4, 1'b0, 32'h00000000};
    tbl[1] = '{1'b0, 14'h0003, 32'h00000000, 0, 0, 32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 14'h0010, 32'h55AA55AA, 0, 0, 32'h00000000, 2, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 14'h0005, 32'h00000000, 0, 1, 32'h11112222, 2, 1'b1, 32'h00000000};
    tbl[4] = '{1'b0, 14'h0006, 32'h00000000, 1, 2, 32'h33334444, 3, 1'b1, 32'h00000000};
    tbl[5] = '{1'b1, 14'h0007, 32'h01020304, 0, 3, 32'h00000000, 9, 1'b1, 32'h00000000};
    tbl[6] = '{1'b1, 14'h0002, 32'hCAFEF00D, 0, 0, 32'h00000000, 2, 1'b0, 32'h00000000};
    tbl[7] = '{1'b0, 14'h3FFF, 32'h00000000, 7, 0, 32'h12345678, 9, 1'b0, 32'h12345678};
    tbl[8] = '{1'b0, 14'h0000, 32'h00000000, 8, 0, 32'h9ABCDEF0, 9, 1'b1, 32'h00000000};
    tbl[9] = '{1'b1, 14'h3FFF, 32'hFFFFFFFF, 5, 1, 32'h00000000, 7, 1'b1, 32'h00000000};

    // Reset state
    repeat (2) @(negedge tb_data_clk);
    chk("rst cyc_stb_we", {m_wb_cyc, m_wb_stb, m_wb_we}, 3'b000);
    chk("rst addr", m_wb_addr, 16'h0);
    chk("rst data_o", m_wb_data_o, 32'h0);
    chk("rst sel", m_wb_sel, 4'h0);
    chk("rst cti_bte", {m_wb_cti, m_wb_bte}, 5'b0);
    chk("rst up_outs", {up_rack, up_rerr, up_wack, up_werr}, 4'b0);
    chk("rst rdata", up_rdata, 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge tb_data_clk);

    // Directed table
    for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    // Slave ack/err while idle must be ignored
    spur = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge tb_data_clk);
      if (up_wack || up_rack || m_wb_cyc) bad = 1'b1;
    end
    spur = 1'b0;
    @(negedge tb_data_clk);
    @(negedge tb_data_clk);
    chk("spurious_ack_ignored", bad, 1'b0);

    // Random transactions against the reference model
    model_rdata = 32'h0;
    for (int i = 0; i < 40; i++) begin
      int r;
      v.wr     = $urandom_range(0, 1);
      v.addr   = WAW'($urandom);
      v.wdata  = $urandom;
      v.sdata  = $urandom | 32'h1;
      v.wait_c = $urandom_range(0, 10);
      r = $urandom_range(0, 9);
      v.resp   = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
      model(v);
      run_txn(v, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 3)) @(negedge tb_data_clk);
    end

    // Simultaneous write and read: write first, idle gap, then read
    sl_wait = 1; sl_resp = 0; sl_data = 32'h0BADF00D;
    stb_cycles = 0; stable = 1'b1; mon_q.delete();
    @(negedge tb_data_clk);
    up_wreq = 1'b1; up_waddr = 14'h0020; up_wdata = 32'h13572468;
    up_rreq = 1'b1; up_raddr = 14'h0021;
    @(negedge tb_data_clk);
    up_wreq = 1'b0; up_rreq = 1'b0;
    wk = 0; rk = 0; wk_err = 1'b1; rk_err = 1'b1; rk_data = '0;
    for (int k = 1; k < 32; k++) begin
      @(negedge tb_data_clk);
      cyc_at[k] = m_wb_cyc;
      if (up_wack && wk == 0) begin wk = k; wk_err = up_werr; end
      if (up_rack && rk == 0) begin rk = k; rk_err = up_rerr; rk_data = up_rdata; end
      if (rk != 0 && k >= rk + 1) break;
    end
    chk("sim wack_time", wk, 3);
    chk("sim rack_time", rk, 7);
    chk("sim errs", {wk_err, rk_err}, 2'b00);
    chk("sim rdata", rk_data, 32'h0BADF00D);
    chk("sim gap", {cyc_at[3], cyc_at[4], cyc_at[5]}, 3'b001);
    chk("sim n_cycles", mon_q.size(), 2);
    if (mon_q.size() == 2) begin
      chk("sim first_is_write", {mon_q[0].we, mon_q[0].addr}, {1'b1, 16'h0080});
      chk("sim second_is_read", {mon_q[1].we, mon_q[1].addr}, {1'b0, 16'h0084});
    end
    chk("sim stable", stable, 1'b1);

    // Asynchronous reset in the middle of a bus cycle, with a read pending
    sl_resp = 3; sl_wait = 0;
    @(negedge tb_data_clk);
    up_wreq = 1'b1; up_waddr = 14'h0040; up_wdata = 32'h77778888;
    @(negedge tb_data_clk);
    up_wreq = 1'b0;
    @(negedge tb_data_clk);
    up_rreq = 1'b1; up_raddr = 14'h0041;
    @(negedge tb_data_clk);
    up_rreq = 1'b0;
    chk("rstbus precond_cyc", m_wb_cyc, 1'b1);
    @(posedge tb_data_clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("rstbus immediate_drop", {m_wb_cyc, m_wb_stb, m_wb_we, m_wb_sel}, 7'b0);
    bad = 1'b0;
    repeat (3) begin
      @(negedge tb_data_clk);
      if (up_wack || up_rack || m_wb_cyc) bad = 1'b1;
    end
    rstn = 1'b1;
    repeat (6) begin
      @(negedge tb_data_clk);
      if (up_wack || up_rack || m_wb_cyc) bad = 1'b1;
    end
    chk("rstbus no_ack_no_pending", bad, 1'b0);
    v = '{1'b1, 14'h0042, 32'h24681357, 0, 0, 32'h00000000, 2, 1'b0, 32'h00000000};
    run_txn(v, "post_rst_write");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
